// File: rtl/axi_wr_arbiter.sv
// N-master AXI write arbiter: serves one AW+W burst at a time and generates W LAST from the granted LEN.
// Define AXI_WR_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (master 0 highest).
`timescale 1ns/1ps
module axi_wr_arbiter #(
    parameter int unsigned M_ID     = 2,
    parameter int unsigned M_WIDTH  = 2,
    localparam int unsigned N       = 1 << M_WIDTH
) (
    input  logic                      BUS_CLK,
    input  logic                      BUS_RSTN,
    input  logic [N*M_ID-1:0]         M_WR_ADDR_ID,
    input  logic [N*32-1:0]           M_WR_ADDR,
    input  logic [N*8-1:0]            M_WR_ADDR_LEN,
    input  logic [N*2-1:0]            M_WR_ADDR_BURST,
    input  logic [N-1:0]              M_WR_ADDR_VALID,
    output logic [N-1:0]              M_WR_ADDR_READY,
    input  logic [N*32-1:0]           M_WR_DATA,
    input  logic [N*4-1:0]            M_WR_STRB,
    input  logic [N-1:0]              M_WR_DATA_LAST,
    input  logic [N-1:0]              M_WR_DATA_VALID,
    output logic [N-1:0]              M_WR_DATA_READY,
    output logic [M_WIDTH+M_ID-1:0]   S_WR_ADDR_ID,
    output logic [31:0]               S_WR_ADDR,
    output logic [7:0]                S_WR_ADDR_LEN,
    output logic [1:0]                S_WR_ADDR_BURST,
    output logic                      S_WR_ADDR_VALID,
    input  logic                      S_WR_ADDR_READY,
    output logic [31:0]               S_WR_DATA,
    output logic [3:0]                S_WR_STRB,
    output logic                      S_WR_DATA_LAST,
    output logic                      S_WR_DATA_VALID,
    input  logic                      S_WR_DATA_READY,
    output logic                      ARB_LAST_ERR
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t              state_q, state_d;
    logic [M_WIDTH-1:0]  grant_q, grant_d, pick;
    logic [7:0]          len_q, len_d, beat_q, beat_d;
    logic                err_q, err_d;
    logic                gen_last, w_fire;
`ifdef AXI_WR_ARB_RR_EN
    logic [M_WIDTH-1:0]  ptr_q, ptr_d;
`endif

    // Request picker; descending scan so the lowest offset from the search start wins
    always_comb begin
        pick = '0;
`ifdef AXI_WR_ARB_RR_EN
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (M_WR_ADDR_VALID[ptr_q + M_WIDTH'(i)]) begin
                pick = ptr_q + M_WIDTH'(i);
            end
        end
`else
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (M_WR_ADDR_VALID[M_WIDTH'(i)]) begin
                pick = M_WIDTH'(i);
            end
        end
`endif
    end

    // Next state, grant bookkeeping and channel routing
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        len_d   = len_q;
        beat_d  = beat_q;
        err_d   = 1'b0;
`ifdef AXI_WR_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        M_WR_ADDR_READY = '0;
        M_WR_DATA_READY = '0;
        S_WR_ADDR_ID    = '0;
        S_WR_ADDR       = '0;
        S_WR_ADDR_LEN   = '0;
        S_WR_ADDR_BURST = '0;
        S_WR_ADDR_VALID = 1'b0;
        S_WR_DATA       = '0;
        S_WR_STRB       = '0;
        S_WR_DATA_LAST  = 1'b0;
        S_WR_DATA_VALID = 1'b0;
        gen_last        = (beat_q == len_q);
        w_fire          = M_WR_DATA_VALID[grant_q] & S_WR_DATA_READY;

        case (state_q)
            IDLE: begin
                if (|M_WR_ADDR_VALID) begin
                    grant_d = pick;
                    len_d   = M_WR_ADDR_LEN[int'(pick)*8 +: 8];
                    state_d = ADDR;
                end
            end
            ADDR: begin
                S_WR_ADDR_VALID          = 1'b1;
                S_WR_ADDR_ID             = {grant_q, M_WR_ADDR_ID[int'(grant_q)*int'(M_ID) +: M_ID]};
                S_WR_ADDR                = M_WR_ADDR[int'(grant_q)*32 +: 32];
                S_WR_ADDR_LEN            = M_WR_ADDR_LEN[int'(grant_q)*8 +: 8];
                S_WR_ADDR_BURST          = M_WR_ADDR_BURST[int'(grant_q)*2 +: 2];
                M_WR_ADDR_READY[grant_q] = S_WR_ADDR_READY;
                if (S_WR_ADDR_READY) begin
                    beat_d  = '0;
                    state_d = DATA;
`ifdef AXI_WR_ARB_RR_EN
                    ptr_d   = grant_q + M_WIDTH'(1);
`endif
                end
            end
            DATA: begin
                S_WR_DATA_VALID          = M_WR_DATA_VALID[grant_q];
                S_WR_DATA                = M_WR_DATA[int'(grant_q)*32 +: 32];
                S_WR_STRB                = M_WR_STRB[int'(grant_q)*4 +: 4];
                S_WR_DATA_LAST           = gen_last;
                M_WR_DATA_READY[grant_q] = S_WR_DATA_READY;
                if (w_fire) begin
                    beat_d = beat_q + 8'd1;
                    err_d  = (M_WR_DATA_LAST[grant_q] != gen_last);
                    if (gen_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and bookkeeping registers; reset aborts any burst in flight
    always_ff @(posedge BUS_CLK or negedge BUS_RSTN) begin
        if (!BUS_RSTN) begin
            state_q <= IDLE;
            grant_q <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
`ifdef AXI_WR_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
`ifdef AXI_WR_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign ARB_LAST_ERR = err_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Scoreboard bench for axi_wr_arbiter: master/slave models drive directed bursts, a negedge monitor checks outputs.
`timescale 1ns/1ps
module tb_axi_wr_arbiter;

    localparam int unsigned NM = 4;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        int          err_beat;
    } job_t;

    typedef struct {
        int          m;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
    } aw_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic        err;
    } w_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [NM-1:0][1:0]  m_id;
    logic [NM-1:0][31:0] m_addr;
    logic [NM-1:0][7:0]  m_len;
    logic [NM-1:0][1:0]  m_burst;
    logic [NM-1:0]       m_av, m_ar;
    logic [NM-1:0][31:0] m_wd;
    logic [NM-1:0][3:0]  m_ws;
    logic [NM-1:0]       m_wl, m_wv, m_wr;
    logic [3:0]  s_awid;
    logic [31:0] s_aw;
    logic [7:0]  s_awlen;
    logic [1:0]  s_awburst;
    logic        s_awv, s_awr;
    logic [31:0] s_wd;
    logic [3:0]  s_ws;
    logic        s_wl, s_wv, s_wr;
    logic        last_err;

    job_t    jq[NM][$];
    aw_exp_t aw_q[$];
    w_exp_t  w_q[$];

    int   checks = 0;
    int   errors = 0;
    int   aw_delay = 0;
    bit   w_toggle = 1'b0;
    int   aw_wait = 0;
    int   cur_m = 0;
    int   w_hs = 0;
    int   aw_stall = 0;
    int   err_seen = 0;
    logic err_exp_now = 1'b0;
    logic [NM-1:0] ar_ok, dr_ok, exp_ar, exp_dr;

    always #5 clk = ~clk;

    axi_wr_arbiter dut (
        .BUS_CLK(clk), .BUS_RSTN(rst_n),
        .M_WR_ADDR_ID(m_id), .M_WR_ADDR(m_addr), .M_WR_ADDR_LEN(m_len), .M_WR_ADDR_BURST(m_burst),
        .M_WR_ADDR_VALID(m_av), .M_WR_ADDR_READY(m_ar),
        .M_WR_DATA(m_wd), .M_WR_STRB(m_ws), .M_WR_DATA_LAST(m_wl), .M_WR_DATA_VALID(m_wv),
        .M_WR_DATA_READY(m_wr),
        .S_WR_ADDR_ID(s_awid), .S_WR_ADDR(s_aw), .S_WR_ADDR_LEN(s_awlen), .S_WR_ADDR_BURST(s_awburst),
        .S_WR_ADDR_VALID(s_awv), .S_WR_ADDR_READY(s_awr),
        .S_WR_DATA(s_wd), .S_WR_STRB(s_ws), .S_WR_DATA_LAST(s_wl), .S_WR_DATA_VALID(s_wv),
        .S_WR_DATA_READY(s_wr), .ARB_LAST_ERR(last_err)
    );

    function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
        return a + 32'(b);
    endfunction

    function automatic logic [3:0] beat_strb(input int b);
        return 4'hF ^ 4'(b);
    endfunction

    function automatic logic mst_last(input job_t j, input int b);
        return (b == int'(j.len)) || (b == j.err_beat);
    endfunction

    function automatic job_t mk(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                                input logic [1:0] burst, input int err_beat);
        job_t j;
        j.id = id; j.addr = addr; j.len = len; j.burst = burst; j.err_beat = err_beat;
        return j;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int m, input job_t j);
        aw_exp_t a;
        w_exp_t  w;
        a.m = m; a.id = {2'(m), j.id}; a.addr = j.addr; a.len = j.len; a.burst = j.burst;
        aw_q.push_back(a);
        for (int b = 0; b <= int'(j.len); b++) begin
            w.data = beat_data(j.addr, b);
            w.strb = beat_strb(b);
            w.last = (b == int'(j.len));
            w.err  = mst_last(j, b) != w.last;
            w_q.push_back(w);
        end
    endtask

    task automatic issue(input int m, input job_t j);
        push_exp(m, j);
        jq[m].push_back(j);
    endtask

    function automatic bit jobs_pending();
        for (int m = 0; m < int'(NM); m++) if (jq[m].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_done(input string name, input int max);
        int t = 0;
        while ((aw_q.size() != 0 || w_q.size() != 0 || jobs_pending()) && t < max) begin
            @(posedge clk);
            t++;
        end
        chk({name, "_done"}, 64'(t < max), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    // Master models: each takes jobs from its own queue and plays the AW then W phase
    for (genvar g = 0; g < NM; g++) begin : mst
        logic [1:0]  g_id;
        logic [31:0] g_addr, g_wd;
        logic [7:0]  g_len;
        logic [1:0]  g_burst;
        logic [3:0]  g_ws;
        logic        g_av, g_wv, g_wl;
        assign m_id[g] = g_id;   assign m_addr[g] = g_addr; assign m_len[g] = g_len;
        assign m_burst[g] = g_burst; assign m_av[g] = g_av; assign m_wd[g] = g_wd;
        assign m_ws[g] = g_ws;   assign m_wv[g] = g_wv;     assign m_wl[g] = g_wl;

        initial begin
            job_t j;
            int   t, b;
            bit   hs, abrt;
            g_id = '0; g_addr = '0; g_len = '0; g_burst = '0; g_av = 1'b0;
            g_wd = '0; g_ws = '0; g_wv = 1'b0; g_wl = 1'b0;
            forever begin
                if (jq[g].size() == 0) begin
                    @(posedge clk); #1;
                end else begin
                    j = jq[g].pop_front();
                    g_id = j.id; g_addr = j.addr; g_len = j.len; g_burst = j.burst; g_av = 1'b1;
                    t = 0; hs = 1'b0; abrt = 1'b0;
                    while (!hs && !abrt && t < 64) begin
                        @(negedge clk); hs = m_ar[g];
                        @(posedge clk); #1; abrt = !rst_n; t++;
                    end
                    g_av = 1'b0; g_id = '0; g_addr = '0; g_len = '0; g_burst = '0;
                    if (!abrt) chk("mst_aw_handshake", 64'(hs), 64'd1);
                    b = 0; t = 0;
                    while (hs && !abrt && b <= int'(j.len) && t < 64) begin
                        g_wv = 1'b1; g_wd = beat_data(j.addr, b); g_ws = beat_strb(b); g_wl = mst_last(j, b);
                        @(negedge clk); hs = m_wr[g];
                        @(posedge clk); #1; abrt = !rst_n; t++;
                        if (hs) b++;
                        hs = 1'b1;
                    end
                    g_wv = 1'b0; g_wd = '0; g_ws = '0; g_wl = 1'b0;
                    if (!abrt && t >= 64) chk("mst_w_timeout", 64'(b), 64'(int'(j.len) + 1));
                end
            end
        end
    end

    // Slave model: AW ready after aw_delay stalled cycles; W ready steady or toggling
    initial begin
        s_awr = 1'b0;
        s_wr  = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (s_awv) begin
                s_awr = (aw_wait >= aw_delay);
                aw_wait++;
            end else begin
                s_awr   = 1'b0;
                aw_wait = 0;
            end
            s_wr = w_toggle ? !s_wr : 1'b1;
        end
    end

    // Monitor: pops and compares on every handshake, checks routing invariants each cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            err_exp_now = 1'b0;
        end else begin
            if (last_err) err_seen++;
            if (last_err || err_exp_now) chk("last_err_pulse", 64'(last_err), 64'(err_exp_now));
            err_exp_now = 1'b0;
            ar_ok = '0;
            dr_ok = '0;
            if (s_awv) begin
                if (aw_q.size() == 0) begin
                    chk("aw_unexpected", 64'(s_awv), 64'd0);
                end else begin
                    ar_ok[aw_q[0].m] = 1'b1;
                    chk("aw_payload", {s_awid, s_aw, s_awlen, s_awburst},
                        {aw_q[0].id, aw_q[0].addr, aw_q[0].len, aw_q[0].burst});
                    if (!s_awr) aw_stall++;
                    if (s_awr) begin
                        cur_m = aw_q[0].m;
                        void'(aw_q.pop_front());
                    end
                end
            end
            if (s_wv) begin
                dr_ok[cur_m] = 1'b1;
                if (s_wr) begin
                    if (w_q.size() == 0) begin
                        chk("w_unexpected", 64'(s_wv), 64'd0);
                    end else begin
                        chk("w_beat", {s_wd, s_ws, s_wl}, {w_q[0].data, w_q[0].strb, w_q[0].last});
                        err_exp_now = w_q[0].err;
                        void'(w_q.pop_front());
                    end
                    w_hs++;
                end
            end
            if (!s_awv && !s_wv) begin
                chk("idle_payload_zero", {s_awid, s_aw, s_awlen, s_awburst, s_wd[15:0]}, 64'd0);
                chk("idle_hi_zero", {s_wd[31:16], s_ws, s_wl}, 64'd0);
            end else begin
                chk("aw_w_exclusive", 64'(s_awv & s_wv), 64'd0);
            end
            exp_ar = s_awv ? (ar_ok & {NM{s_awr}}) : '0;
            exp_dr = s_wv  ? (dr_ok & {NM{s_wr}})  : '0;
            chk("ready_routing", {m_ar, m_wr}, {exp_ar, exp_dr});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {s_awv, s_wv, s_wl, m_ar, m_wr, last_err}, 64'd0);
        chk("reset_payload", {s_awid, s_aw, s_awlen, s_awburst}, 64'd0);
        rst_n = 1'b1;

        // Master 2, LEN=3, slave always ready
        issue(2, mk(2'd1, 32'h1000_0000, 8'd3, 2'b01, -1));
        wait_done("m2_len3", 100);

        // Early master LAST on beat 2 of LEN=3
        base = err_seen;
        issue(1, mk(2'd3, 32'h2000_0040, 8'd3, 2'b01, 1));
        wait_done("early_last", 100);
        chk("early_last_err_count", 64'(err_seen - base), 64'd1);

        // AW ready held low for 5 cycles
        base = aw_stall;
        aw_delay = 5;
        issue(3, mk(2'd2, 32'h3000_0100, 8'd1, 2'b10, -1));
        wait_done("aw_stall", 100);
        chk("aw_stall_cycles", 64'(aw_stall - base), 64'd5);
        aw_delay = 0;

        // Toggling W ready during LEN=3
        base = w_hs;
        w_toggle = 1'b1;
        issue(0, mk(2'd0, 32'h4000_0000, 8'd3, 2'b01, -1));
        wait_done("w_toggle", 100);
        chk("w_toggle_beats", 64'(w_hs - base), 64'd4);
        w_toggle = 1'b0;

        // Masters 0 and 1 competing with LEN=0; fresh reset so arbitration starts from master 0
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef AXI_WR_ARB_RR_EN
        push_exp(0, mk(2'd1, 32'hA000_0000, 8'd0, 2'b01, -1));
        push_exp(1, mk(2'd2, 32'hB000_0000, 8'd0, 2'b01, -1));
        push_exp(0, mk(2'd3, 32'hA000_0010, 8'd0, 2'b01, -1));
        push_exp(1, mk(2'd0, 32'hB000_0010, 8'd0, 2'b01, -1));
`else
        push_exp(0, mk(2'd1, 32'hA000_0000, 8'd0, 2'b01, -1));
        push_exp(0, mk(2'd3, 32'hA000_0010, 8'd0, 2'b01, -1));
        push_exp(1, mk(2'd2, 32'hB000_0000, 8'd0, 2'b01, -1));
        push_exp(1, mk(2'd0, 32'hB000_0010, 8'd0, 2'b01, -1));
`endif
        jq[0].push_back(mk(2'd1, 32'hA000_0000, 8'd0, 2'b01, -1));
        jq[0].push_back(mk(2'd3, 32'hA000_0010, 8'd0, 2'b01, -1));
        jq[1].push_back(mk(2'd2, 32'hB000_0000, 8'd0, 2'b01, -1));
        jq[1].push_back(mk(2'd0, 32'hB000_0010, 8'd0, 2'b01, -1));
        wait_done("arb_order", 200);

        // Reset during beat 2 of LEN=7, then a normal burst
        base = w_hs;
        issue(3, mk(2'd2, 32'h5000_0000, 8'd7, 2'b01, -1));
        t = 0;
        while (w_hs < base + 1 && t < 50) begin
            @(posedge clk);
            t++;
        end
        chk("mid_burst_reached", 64'(t < 50), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_reset_valid_ready", {s_awv, s_wv, s_wl, m_ar, m_wr, last_err}, 64'd0);
        w_q.delete();
        aw_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_reset_idle", {s_awv, s_wv}, 64'd0);
        issue(1, mk(2'd1, 32'h6000_0000, 8'd1, 2'b00, -1));
        wait_done("after_reset", 100);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 The block SHALL have parameter M_ID, default 2, meaning master-side transaction ID width.
REQ-002 The block SHALL have parameter M_WIDTH, default 2, meaning the block serves N = 2**M_WIDTH masters.
REQ-003 The block SHALL have these ports, clock and reset first:
- BUS_CLK  in  1  bus clock.
- BUS_RSTN  in  1  bus reset.
- M_WR_ADDR_ID / M_WR_ADDR / M_WR_ADDR_LEN / M_WR_ADDR_BURST  in  [N][M_ID]/[N][32]/[N][8]/[N][2]  per-master AW payload.
- M_WR_ADDR_VALID  in  [N]  per-master AW valid.
- M_WR_ADDR_READY  out  [N]  per-master AW ready.
- M_WR_DATA / M_WR_STRB / M_WR_DATA_LAST / M_WR_DATA_VALID  in  [N][32]/[N][4]/[N]/[N]  per-master W channel.
- M_WR_DATA_READY  out  [N]  per-master W ready.
- S_WR_ADDR_ID  out  M_WIDTH+M_ID  {granted master index, master ID}.
- S_WR_ADDR / S_WR_ADDR_LEN / S_WR_ADDR_BURST  out  32/8/2  forwarded AW payload.
- S_WR_ADDR_VALID  out  1; S_WR_ADDR_READY  in  1.
- S_WR_DATA / S_WR_STRB / S_WR_DATA_LAST / S_WR_DATA_VALID  out  32/4/1/1; S_WR_DATA_READY  in  1.
- ARB_LAST_ERR  out  1  one-cycle pulse on a master LAST/length mismatch.
REQ-004 The block SHALL use one clock, BUS_CLK, with reset BUS_RSTN asynchronous and active-low.

Function
REQ-005 The block SHALL implement states IDLE, ADDR, DATA.
REQ-006 In IDLE with any M_WR_ADDR_VALID high, the block SHALL register the grant index and LEN and enter ADDR on the next edge; with none valid it SHALL remain in IDLE.
REQ-007 In ADDR, S_WR_ADDR_VALID SHALL be 1 with the granted master's payload, and only the granted M_WR_ADDR_READY SHALL mirror S_WR_ADDR_READY.
REQ-008 On the AW handshake (valid & ready), the block SHALL clear the beat counter and enter DATA; the AW SHALL hold otherwise.
REQ-009 In DATA, the granted master's W signals SHALL be forwarded combinationally (valid, data, strb), and only its M_WR_DATA_READY SHALL mirror S_WR_DATA_READY.
REQ-010 All W ready outputs SHALL be 0 outside DATA, and all non-granted ready outputs SHALL be 0 in every state.
REQ-011 S_WR_DATA_LAST SHALL be generated as (beat counter == registered LEN); the master's LAST SHALL NOT drive it.
REQ-012 Each W handshake SHALL increment the 8-bit beat counter; the handshake with S_WR_DATA_LAST=1 SHALL return the block to IDLE.
REQ-013 ARB_LAST_ERR SHALL pulse for one cycle, registered, when a W handshake's master LAST differs from the generated LAST.
REQ-014 One idle cycle SHALL separate consecutive bursts, so the maximum is one burst per LEN+3 cycles.
REQ-015 With LEN=0, the first W beat SHALL carry LAST=1.
REQ-016 The grant SHALL NOT change between IDLE exit and burst completion, even if the granted master drops AW valid (protocol violation, not checked).

Reset
REQ-017 On BUS_RSTN low, the block SHALL immediately set state=IDLE, grant=0, beat counter=0, RR pointer=0, ARB_LAST_ERR=0, and all VALID and READY outputs to 0, including mid-burst; the aborted burst SHALL NOT be resumed.
REQ-018 Payload outputs SHALL be 0 while in IDLE.

Configuration
REQ-019 With macro AXI_WR_ARB_RR_EN defined, arbitration SHALL be round-robin: the search starts at the pointer, and the pointer SHALL become (grant+1) mod N on each AW handshake.
REQ-020 Without AXI_WR_ARB_RR_EN, arbitration SHALL be fixed priority with master 0 highest, and no pointer register SHALL exist.

Verification
REQ-021 Master 2 AW valid, LEN=3, slave always ready -> S_WR_ADDR_ID={2'd2,ID}, 4 W beats forwarded, LAST on beat 4, IDLE after.
REQ-022 Masters 0 and 1 both continuously requesting LEN=0, RR build -> grants alternate 0,1,0,1; fixed build -> always 0.
REQ-023 Master sends LAST on beat 2 of LEN=3 -> ARB_LAST_ERR pulses once, S_WR_DATA_LAST stays 0 until beat 4.
REQ-024 S_WR_ADDR_READY held low 5 cycles -> AW payload stable, no W ready, DATA entered only after handshake.
REQ-025 BUS_RSTN asserted during beat 2 of LEN=7 -> all valid/ready 0 immediately, IDLE after release, next request served normally.
REQ-026 S_WR_DATA_READY toggled 1,0,1,0 during LEN=3 -> exactly 4 beats counted, non-granted readys stay 0.
